// File: rtl/ssp_pkg.sv
// Shared types and constants for the SSP frame sequencer and its Rx deserializer.
package ssp_pkg;

  localparam int SSP_DATA_W = 8;

  // Wide enough to hold a count of 0..dataW inclusive.
  function automatic int sspCntWidth(input int dataW);
    return $clog2(dataW + 1);
  endfunction

  localparam int SSP_CNT_W = sspCntWidth(SSP_DATA_W);

  typedef enum logic [1:0] {IDLE, FRAME, SHIFT} tx_state_t;
  typedef enum logic       {WAIT, RECV}         rx_state_t;

endpackage

// File: rtl/ssp_rx_deserializer.sv
// SSP receive path: detects serial clock rises, assembles MSB-first words and
// pushes them into the Rx FIFO, flagging an overrun when the FIFO is full.
module ssp_rx_deserializer
  import ssp_pkg::*;
#(
  parameter int DATA_W = SSP_DATA_W
) (
  input  logic              clk_i,
  input  logic              clear_i,
  input  logic              sclk_i,
  input  logic              fss_i,
  input  logic              rxd_i,
  input  logic              rxFull_i,
  output logic [DATA_W-1:0] rxData_o,
  output logic              push_o,
  output logic              ovr_o
);
  localparam int CntW = sspCntWidth(DATA_W);

  rx_state_t         stateQ, stateD;
  logic [DATA_W-2:0] shiftQ, shiftD;
  logic [CntW-1:0]   cntQ, cntD;
  logic [DATA_W-1:0] dataQ, dataD;
  logic              sclkPrevQ;
  logic              pushQ, pushD;
  logic              ovrQ, ovrD;
  logic              sclkRise;
  logic [DATA_W-1:0] word;

  assign sclkRise = sclk_i & ~sclkPrevQ;
  assign word     = {shiftQ, rxd_i};

  always_ff @(posedge clk_i) begin
    if (clear_i) begin
      stateQ    <= WAIT;
      shiftQ    <= '0;
      cntQ      <= '0;
      dataQ     <= '0;
      sclkPrevQ <= 1'b0;
      pushQ     <= 1'b0;
      ovrQ      <= 1'b0;
    end else begin
      stateQ    <= stateD;
      shiftQ    <= shiftD;
      cntQ      <= cntD;
      dataQ     <= dataD;
      sclkPrevQ <= sclk_i;
      pushQ     <= pushD;
      ovrQ      <= ovrD;
    end
  end

  // A frame sync seen on the last-bit rise keeps us in RECV for a back-to-back word.
  always_comb begin
    stateD = stateQ;
    shiftD = shiftQ;
    cntD   = cntQ;
    dataD  = dataQ;
    pushD  = 1'b0;
    ovrD   = 1'b0;
    case (stateQ)
      WAIT: begin
        if (sclkRise && fss_i) begin
          stateD = RECV;
          cntD   = '0;
        end
      end
      RECV: begin
        if (sclkRise) begin
          shiftD = word[DATA_W-2:0];
          cntD   = cntQ + 1'b1;
          if (cntQ == CntW'(DATA_W - 1)) begin
            cntD = '0;
            if (rxFull_i) begin
              ovrD = 1'b1;
            end else begin
              dataD = word;
              pushD = 1'b1;
            end
            stateD = fss_i ? RECV : WAIT;
          end
        end
      end
      default: stateD = WAIT;
    endcase
  end

  assign rxData_o = dataQ;
  assign push_o   = pushQ;
  assign ovr_o    = ovrQ;

endmodule

// File: rtl/ssp_frame_sequencer.sv
// SSP serial-side sequencer: PCLK/2 serial clock, Tx framing and MSB-first shifting,
// Rx via ssp_rx_deserializer. Define SSP_LOOPBACK_EN to feed Rx from the Tx pins.
module ssp_frame_sequencer
  import ssp_pkg::*;
#(
  parameter int DATA_W = SSP_DATA_W
) (
  input  logic              PCLK,
  input  logic              CLEAR,
  input  logic [DATA_W-1:0] TxDATA,
  input  logic              TxEMPTY,
  output logic              TxLOGICWRITE,
  input  logic              RxFULL,
  output logic [DATA_W-1:0] RxDATA,
  output logic              RxLOGICWRITE,
  output logic              RX_OVR,
  input  logic              SSPCLKIN,
  input  logic              SSPFSSIN,
  input  logic              SSPRXD,
  output logic              SSPCLKOUT,
  output logic              SSPFSSOUT,
  output logic              SSPTXD,
  output logic              SSPOE_B
);
  localparam int CntW = sspCntWidth(DATA_W);

  tx_state_t         txStateQ, txStateD;
  logic [DATA_W-1:0] shiftQ, shiftD;
  logic [CntW-1:0]   bitCntQ, bitCntD;
  logic              clkOutQ;
  logic              fssQ, fssD;
  logic              txdQ, txdD;
  logic              oeBQ, oeBD;
  logic              popQ, popD;
  logic              tailQ, tailD;
  logic              rise;
  logic              rxClk, rxFss, rxSd;

  assign rise = ~clkOutQ;

  always_ff @(posedge PCLK) begin
    if (CLEAR) begin
      txStateQ <= IDLE;
      shiftQ   <= '0;
      bitCntQ  <= '0;
      clkOutQ  <= 1'b0;
      fssQ     <= 1'b0;
      txdQ     <= 1'b0;
      oeBQ     <= 1'b1;
      popQ     <= 1'b0;
      tailQ    <= 1'b0;
    end else begin
      txStateQ <= txStateD;
      shiftQ   <= shiftD;
      bitCntQ  <= bitCntD;
      clkOutQ  <= ~clkOutQ;
      fssQ     <= fssD;
      txdQ     <= txdD;
      oeBQ     <= oeBD;
      popQ     <= popD;
      tailQ    <= tailD;
    end
  end

  // tailQ marks the extra period that holds the final bit before the line is released.
  always_comb begin
    txStateD = txStateQ;
    shiftD   = shiftQ;
    bitCntD  = bitCntQ;
    fssD     = fssQ;
    txdD     = txdQ;
    oeBD     = oeBQ;
    popD     = 1'b0;
    tailD    = tailQ;
    case (txStateQ)
      IDLE: begin
        if (rise && !TxEMPTY) begin
          fssD     = 1'b1;
          shiftD   = TxDATA;
          popD     = 1'b1;
          txStateD = FRAME;
        end
      end
      FRAME: begin
        if (!rise) begin
          oeBD = 1'b0;
        end else begin
          fssD     = 1'b0;
          txdD     = shiftQ[DATA_W-1];
          shiftD   = {shiftQ[DATA_W-2:0], 1'b0};
          bitCntD  = CntW'(1);
          txStateD = SHIFT;
        end
      end
      SHIFT: begin
        if (rise) begin
          if (bitCntQ == CntW'(DATA_W)) begin
            tailD = 1'b1;
          end else begin
            txdD    = shiftQ[DATA_W-1];
            shiftD  = {shiftQ[DATA_W-2:0], 1'b0};
            bitCntD = bitCntQ + 1'b1;
            if (bitCntQ == CntW'(DATA_W - 1) && !TxEMPTY) begin
              shiftD   = TxDATA;
              popD     = 1'b1;
              fssD     = 1'b1;
              bitCntD  = '0;
              txStateD = FRAME;
            end
          end
        end else if (tailQ) begin
          oeBD     = 1'b1;
          txdD     = 1'b0;
          tailD    = 1'b0;
          bitCntD  = '0;
          txStateD = IDLE;
        end
      end
      default: txStateD = IDLE;
    endcase
  end

`ifdef SSP_LOOPBACK_EN
  assign rxClk   = clkOutQ;
  assign rxFss   = fssQ;
  assign rxSd    = txdQ;
  assign SSPOE_B = 1'b1;
`else
  assign rxClk   = SSPCLKIN;
  assign rxFss   = SSPFSSIN;
  assign rxSd    = SSPRXD;
  assign SSPOE_B = oeBQ;
`endif

  ssp_rx_deserializer #(
    .DATA_W(DATA_W)
  ) uRx (
    .clk_i   (PCLK),
    .clear_i (CLEAR),
    .sclk_i  (rxClk),
    .fss_i   (rxFss),
    .rxd_i   (rxSd),
    .rxFull_i(RxFULL),
    .rxData_o(RxDATA),
    .push_o  (RxLOGICWRITE),
    .ovr_o   (RX_OVR)
  );

  assign TxLOGICWRITE = popQ;
  assign SSPCLKOUT    = clkOutQ;
  assign SSPFSSOUT    = fssQ;
  assign SSPTXD       = txdQ;

endmodule
